// File: rtl/config_frame_pkg.sv
// Shared definitions for the frame configuration controller: session states,
// the default sync word and the header word field layout.
package config_frame_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        DATA   = 2'd2,
        STROBE = 2'd3
    } state_t;

    localparam logic [31:0] SYNC_WORD = 32'hFAB0_FAB1;

    localparam int DESYNC_BIT  = 31;
    localparam int INDEX_LSB   = 0;
    localparam int INDEX_MSB   = 7;
    localparam int INDEX_WIDTH = INDEX_MSB - INDEX_LSB + 1;

endpackage

// File: rtl/config_strobe_decoder.sv
// Registered binary-to-one-hot decoder driving the column's frame latch strobes.
// The output is a plain register, so it can never glitch or go multi-hot.
module config_strobe_decoder #(
    parameter int MaxFramesPerCol = 20,
    parameter int IndexWidth      = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic [IndexWidth-1:0]      index,
    output logic [MaxFramesPerCol-1:0] strobe
);

    logic [MaxFramesPerCol-1:0] strobe_next;

    always_comb begin
        strobe_next = '0;
        for (int i = 0; i < MaxFramesPerCol; i++) begin
            strobe_next[i] = enable && (index == IndexWidth'(i));
        end
    end

    // Dropping enable clears the pulse on the next edge, giving a one-cycle strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            strobe <= '0;
        end else begin
            strobe <= strobe_next;
        end
    end

endmodule

// File: rtl/config_frame_controller.sv
// Decodes a sync-delimited stream of header/data word pairs into frame data
// plus a one-cycle frame latch strobe for a single fabric column.
module config_frame_controller
    import config_frame_pkg::*;
#(
    parameter int          FrameBitsPerRow = 32,
    parameter int          MaxFramesPerCol = 20,
    parameter logic [31:0] SyncWord        = SYNC_WORD
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic [31:0]                s_data,
    input  logic                       s_valid,
    output logic                       s_ready,
    output logic [FrameBitsPerRow-1:0] FrameData,
    output logic [MaxFramesPerCol-1:0] FrameStrobe,
    output logic                       busy,
    output logic                       error,
    output logic [15:0]                frames_written
);

    state_t                 state;
    logic [INDEX_WIDTH-1:0] frame_index;
    logic                   drop;
    logic                   accept;
    logic                   header_desync;
    logic [INDEX_WIDTH-1:0] header_index;
    logic                   index_valid;
    logic                   strobe_enable;

    assign s_ready       = (state != STROBE);
    assign busy          = (state != IDLE);
    assign accept        = s_valid && s_ready;
    assign header_desync = s_data[DESYNC_BIT];
    assign header_index  = s_data[INDEX_MSB:INDEX_LSB];
    assign index_valid   = {1'b0, header_index} < (INDEX_WIDTH + 1)'(MaxFramesPerCol);

    // The strobe is registered on the same edge that captures FrameData.
    assign strobe_enable = accept && (state == DATA) && !drop;

    // A header with an out-of-range index still consumes its data word; the
    // drop flag swallows that word so the pair stays aligned.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state          <= IDLE;
            frame_index    <= '0;
            drop           <= 1'b0;
            error          <= 1'b0;
            FrameData      <= '0;
            frames_written <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && (s_data == SyncWord)) begin
                        state <= HEADER;
                    end
                end
                HEADER: begin
                    if (accept) begin
                        if (header_desync) begin
                            state <= IDLE;
                        end else begin
                            state <= DATA;
                            if (index_valid) begin
                                frame_index <= header_index;
                            end else begin
                                error <= 1'b1;
                                drop  <= 1'b1;
                            end
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
                        if (drop) begin
                            drop  <= 1'b0;
                            state <= HEADER;
                        end else begin
                            FrameData <= s_data[FrameBitsPerRow-1:0];
                            state     <= STROBE;
                        end
                    end
                end
                STROBE: begin
                    state <= HEADER;
                    if (frames_written != 16'hFFFF) begin
                        frames_written <= frames_written + 16'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    config_strobe_decoder #(
        .MaxFramesPerCol(MaxFramesPerCol),
        .IndexWidth     (INDEX_WIDTH)
    ) strobe_decoder (
        .clk   (CLK),
        .rst   (RESET),
        .enable(strobe_enable),
        .index (frame_index),
        .strobe(FrameStrobe)
    );

endmodule

// File: tb/tb_config_frame_controller.sv
// Randomised and directed bench for config_frame_controller; expected frames come
// from a word-stream parser model that runs as each word is queued for sending.
module tb_config_frame_controller;
    import config_frame_pkg::*;

    localparam int FBR = 32;
    localparam int MFC = 20;

    logic           CLK = 1'b0;
    logic           RESET;
    logic [31:0]    s_data;
    logic           s_valid;
    logic           s_ready;
    logic [FBR-1:0] FrameData;
    logic [MFC-1:0] FrameStrobe;
    logic           busy;
    logic           error;
    logic [15:0]    frames_written;

    config_frame_controller #(
        .FrameBitsPerRow(FBR),
        .MaxFramesPerCol(MFC),
        .SyncWord       (SYNC_WORD)
    ) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .FrameData     (FrameData),
        .FrameStrobe   (FrameStrobe),
        .busy          (busy),
        .error         (error),
        .frames_written(frames_written)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int          idx;
        logic [31:0] data;
        int          pos;
    } frame_t;

    frame_t      exp_q[$];
    logic [31:0] stim_q[$];
    int          acc_cycle[int];
    int          strobe_cycles[$];
    int          push_count = 0;
    int          acc_count  = 0;

    // Parser model: 0 = waiting for sync, 1 = expecting header, 2 = expecting data
    int          m_phase     = 0;
    int          m_idx       = 0;
    bit          m_drop      = 1'b0;
    bit          m_err       = 1'b0;
    int          m_frames    = 0;
    logic [31:0] m_last_data = '0;

    int checks = 0;
    int errors = 0;

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        stim_q.push_back(w);
        case (m_phase)
            0: if (w == SYNC_WORD) m_phase = 1;
            1: begin
                if (w[31]) begin
                    m_phase = 0;
                end else begin
                    m_idx  = int'(w[7:0]);
                    m_drop = (m_idx >= MFC);
                    if (m_drop) m_err = 1'b1;
                    m_phase = 2;
                end
            end
            default: begin
                if (!m_drop) begin
                    exp_q.push_back('{m_idx, w, push_count});
                    m_last_data = w;
                    if (m_frames < 65535) m_frames++;
                end
                m_drop  = 1'b0;
                m_phase = 1;
            end
        endcase
        push_count++;
    endtask

    task automatic monitor_strobe();
        frame_t e;
        if (FrameStrobe !== '0) begin
            strobe_cycles.push_back(cyc);
            if (exp_q.size() == 0) begin
                check_output("unexpected_strobe", 64'(FrameStrobe), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check_output("strobe_onehot", 64'(FrameStrobe), 64'd1 << e.idx);
                check_output("strobe_data", 64'(FrameData), 64'(e.data));
                check_output("strobe_latency", 64'(cyc), 64'(acc_cycle[e.pos] + 1));
                check_output("strobe_ready_low", 64'(s_ready), 64'd0);
            end
        end
    endtask

    // Streams the queued words with s_valid asserted pct percent of the time.
    task automatic apply_stimulus(input int pct, input int max_cycles);
        int n = 0;
        bit rdy;
        while ((stim_q.size() > 0 || exp_q.size() > 0) && n < max_cycles) begin
            @(negedge CLK);
            monitor_strobe();
            rdy = s_ready;
            if (stim_q.size() > 0 && $urandom_range(99) < pct) begin
                s_valid = 1'b1;
                s_data  = stim_q[0];
            end else begin
                s_valid = 1'b0;
                s_data  = $urandom;
            end
            if (s_valid && rdy) begin
                void'(stim_q.pop_front());
                acc_cycle[acc_count] = cyc;
                acc_count++;
            end
            n++;
        end
        check_output("stream_drained", 64'(stim_q.size() + exp_q.size()), 64'd0);
        repeat (3) begin
            @(negedge CLK);
            s_valid = 1'b0;
            monitor_strobe();
        end
    endtask

    task automatic check_idle_state(input string tag);
        $display("[TB] state check: %s", tag);
        check_output({tag, "_busy"}, 64'(busy), 64'(m_phase != 0));
        check_output({tag, "_error"}, 64'(error), 64'(m_err));
        check_output({tag, "_frames"}, 64'(frames_written), 64'(m_frames));
        check_output({tag, "_framedata"}, 64'(FrameData), 64'(m_last_data));
        check_output({tag, "_ready"}, 64'(s_ready), 64'd1);
        check_output({tag, "_strobe"}, 64'(FrameStrobe), 64'd0);
    endtask

    task automatic reset_model();
        m_phase     = 0;
        m_drop      = 1'b0;
        m_err       = 1'b0;
        m_frames    = 0;
        m_last_data = '0;
        stim_q.delete();
        exp_q.delete();
        acc_count = push_count;
    endtask

    task automatic do_reset();
        s_valid = 1'b0;
        s_data  = '0;
        RESET   = 1'b1;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        reset_model();
    endtask

    initial begin
        int base;
        logic [31:0] w;

        RESET   = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;

        // Scenario 1: single frame with s_valid held high
        do_reset();
        check_idle_state("reset");
        base = push_count;
        push_word(SYNC_WORD);
        push_word(32'h0000_0003);
        push_word(32'hDEAD_BEEF);
        apply_stimulus(100, 40);
        check_output("s1_accept_spacing", 64'(acc_cycle[base + 2] - acc_cycle[base]), 64'd2);
        check_idle_state("s1");

        // Back-to-back frames: one frame every three cycles
        strobe_cycles.delete();
        for (int i = 0; i < 3; i++) begin
            push_word(32'(i + 1));
            push_word($urandom);
        end
        apply_stimulus(100, 40);
        check_output("thru_count", 64'(strobe_cycles.size()), 64'd3);
        if (strobe_cycles.size() == 3) begin
            check_output("thru_gap0", 64'(strobe_cycles[1] - strobe_cycles[0]), 64'd3);
            check_output("thru_gap1", 64'(strobe_cycles[2] - strobe_cycles[1]), 64'd3);
        end
        check_idle_state("thru");

        // Scenario 2: words before sync are discarded
        do_reset();
        push_word(32'h1234_5678);
        push_word(32'h0000_0000);
        apply_stimulus(100, 40);
        check_idle_state("s2_presync");
        push_word(SYNC_WORD);
        apply_stimulus(100, 40);
        check_idle_state("s2_sync");

        // Scenario 3: out-of-range index sets sticky error and drops its data
        push_word(32'h0000_0019);
        push_word(32'hAAAA_5555);
        push_word(32'h0000_0000);
        push_word(32'h0000_0001);
        apply_stimulus(70, 80);
        check_idle_state("s3");

        // Scenario 4: desync returns to idle; next word ignored, error stays set
        push_word(32'h8000_0005);
        push_word(32'hCAFE_0001);
        apply_stimulus(70, 80);
        check_idle_state("s4");

        // Scenario 5: random s_valid over a three-frame session
        do_reset();
        push_word(SYNC_WORD);
        push_word(32'd0);
        push_word($urandom);
        push_word(32'd19);
        push_word($urandom);
        push_word(32'd7);
        push_word($urandom);
        apply_stimulus(50, 200);
        check_idle_state("s5");

        // Random traffic: headers, bad indices, desyncs, resyncs and garbage
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(9))
                0: w = SYNC_WORD;
                1: w = 32'h8000_0000 | 32'($urandom_range(255));
                2: w = $urandom;
                default: w = 32'($urandom_range(31)) | ({$urandom} & 32'h7FFF_FF00);
            endcase
            push_word(w);
            if (m_phase == 2) push_word($urandom);
        end
        apply_stimulus($urandom_range(30, 100), 2000);
        check_idle_state("rand");

        // Scenario 6: asynchronous reset in the middle of a strobe cycle
        do_reset();
        @(negedge CLK);
        s_valid = 1'b1;
        s_data  = SYNC_WORD;
        @(negedge CLK);
        s_data = 32'h0000_0002;
        @(negedge CLK);
        s_data = 32'h1357_2468;
        @(negedge CLK);
        s_valid = 1'b0;
        check_output("s6_strobe_pre", 64'(FrameStrobe), 64'h4);
        check_output("s6_data_pre", 64'(FrameData), 64'h1357_2468);
        #1 RESET = 1'b1;
        #1;
        check_output("s6_strobe_async", 64'(FrameStrobe), 64'd0);
        check_output("s6_data_async", 64'(FrameData), 64'd0);
        check_output("s6_busy_async", 64'(busy), 64'd0);
        check_output("s6_ready_async", 64'(s_ready), 64'd1);
        @(negedge CLK);
        RESET = 1'b0;
        reset_model();
        check_idle_state("s6_reset");
        push_word(SYNC_WORD);
        push_word(32'h0000_0003);
        push_word(32'hDEAD_BEEF);
        apply_stimulus(100, 40);
        check_idle_state("s6_fresh");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
